// File: rtl/noc_resp_axi_pkg.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | noc_resp_axi_pkg                                                       |
// | Shared constants, FSM encoding and NoC message classification for     |
// | the NoC-response to AXI R/B channel generator.                        |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
package noc_resp_axi_pkg;

  localparam int c_MSG_LENGTH_WIDTH = 8;
  localparam int c_MSG_TYPE_WIDTH   = 8;
  localparam int c_MSG_LENGTH_LO    = 22;
  localparam int c_MSG_TYPE_LO      = 14;

  localparam logic [c_MSG_TYPE_WIDTH-1:0] c_MSG_TYPE_NC_LOAD_MEM_ACK  = 8'd26;
  localparam logic [c_MSG_TYPE_WIDTH-1:0] c_MSG_TYPE_NC_STORE_MEM_ACK = 8'd27;
  localparam logic [c_MSG_TYPE_WIDTH-1:0] c_MSG_TYPE_NODATA_ACK       = 8'd28;
  localparam logic [c_MSG_TYPE_WIDTH-1:0] c_MSG_TYPE_DATA_ACK         = 8'd29;

  localparam logic [1:0] c_AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] c_AXI_RESP_SLVERR = 2'b10;

  typedef logic [1:0] state_t;
  localparam state_t c_ST_HEADER    = 2'd0;
  localparam state_t c_ST_LOAD_DATA = 2'd1;
  localparam state_t c_ST_BRESP     = 2'd2;
  localparam state_t c_ST_DROP      = 2'd3;

  typedef enum logic [1:0] {
    MSG_CLASS_OTHER = 2'd0,
    MSG_CLASS_LOAD  = 2'd1,
    MSG_CLASS_STORE = 2'd2
  } msg_class_e;

  function automatic msg_class_e classify_msg(input logic [c_MSG_TYPE_WIDTH-1:0] msg_type);
    case (msg_type)
      c_MSG_TYPE_DATA_ACK, c_MSG_TYPE_NC_LOAD_MEM_ACK:    return MSG_CLASS_LOAD;
      c_MSG_TYPE_NODATA_ACK, c_MSG_TYPE_NC_STORE_MEM_ACK: return MSG_CLASS_STORE;
      default:                                            return MSG_CLASS_OTHER;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | sync_fifo                                                              |
// | Single-clock FIFO with show-ahead read data and occupancy counter.    |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  output logic             full,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             empty
);

  localparam int c_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [c_AW-1:0] c_LAST_PTR = c_AW'(DEPTH - 1);
  localparam logic [c_AW:0]   c_FULL_CNT = (c_AW + 1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [c_AW-1:0]  r_wr_ptr;
  logic [c_AW-1:0]  r_rd_ptr;
  logic [c_AW:0]    r_count;
  logic             w_push;
  logic             w_pop;

  assign full    = (r_count == c_FULL_CNT);
  assign empty   = (r_count == '0);
  assign rd_data = r_mem[r_rd_ptr];

  // A write while full is accepted only when the head leaves in the same cycle.
  assign w_push = wr_en && (!full || rd_en);
  assign w_pop  = rd_en && !empty;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= (r_wr_ptr == c_LAST_PTR) ? '0 : r_wr_ptr + c_AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= (r_rd_ptr == c_LAST_PTR) ? '0 : r_rd_ptr + c_AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (c_AW + 1)'(1);
        2'b01:   r_count <= r_count - (c_AW + 1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/noc_response_axi_gen.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | noc_response_axi_gen                                                   |
// | Converts NoC response messages into AXI R beats / B responses,        |
// | matched in order against a queue of expected transaction types.       |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
module noc_response_axi_gen
  import noc_resp_axi_pkg::*;
#(
  parameter int NOC_DATA_WIDTH = 64,
  parameter int AXI_DATA_WIDTH = 512,
  parameter int SWAP_ENDIANESS = 1,
  parameter int TXN_DEPTH      = 16,
  parameter int RDATA_DEPTH    = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      noc_valid_in,
  input  logic [NOC_DATA_WIDTH-1:0] noc_data_in,
  output logic                      noc_ready_out,
  input  logic                      txn_valid_in,
  input  logic                      txn_is_store,
  output logic                      txn_ready_out,
  output logic [AXI_DATA_WIDTH-1:0] m_axi_rdata,
  output logic [1:0]                m_axi_rresp,
  output logic                      m_axi_rvalid,
  input  logic                      m_axi_rready,
  output logic [1:0]                m_axi_bresp,
  output logic                      m_axi_bvalid,
  input  logic                      m_axi_bready,
  output logic                      err_unexpected
);

  localparam int c_RATIO  = AXI_DATA_WIDTH / NOC_DATA_WIDTH;
  localparam int c_LANE_W = (c_RATIO > 1) ? $clog2(c_RATIO) : 1;
  localparam int c_BYTES  = NOC_DATA_WIDTH / 8;
  localparam int c_RD_W   = AXI_DATA_WIDTH + 2;
  localparam logic [c_LANE_W-1:0]           c_LANE_LAST = c_LANE_W'(c_RATIO - 1);
  localparam logic [c_MSG_LENGTH_WIDTH-1:0] c_CNT_ONE   = c_MSG_LENGTH_WIDTH'(1);

  state_t                          r_state;
  logic [c_MSG_LENGTH_WIDTH-1:0]   r_msg_len;
  logic [c_MSG_LENGTH_WIDTH-1:0]   r_flit_cnt;
  logic [c_LANE_W-1:0]             r_lane;
  logic [AXI_DATA_WIDTH-1:0]       r_beat;
  logic                            r_bvalid;
  logic [1:0]                      r_bresp;
  logic                            r_err;

  logic [NOC_DATA_WIDTH-1:0]       w_flit_swapped;
  logic [c_MSG_LENGTH_WIDTH-1:0]   w_hdr_len;
  logic [c_MSG_TYPE_WIDTH-1:0]     w_hdr_type;
  msg_class_e                      w_hdr_class;
  logic                            w_hdr_match;
  logic                            w_txn_full;
  logic                            w_txn_empty;
  logic                            w_txn_head;
  logic                            w_txn_avail;
  logic                            w_txn_push;
  logic                            w_txn_pop;
  logic                            w_rd_full;
  logic                            w_rd_empty;
  logic [c_RD_W-1:0]               w_rd_head;
  logic                            w_rd_push;
  logic [c_RD_W-1:0]               w_rd_push_data;
  logic                            w_rd_pop;
  logic                            w_noc_ready;
  logic                            w_noc_fire;
  logic                            w_last_flit;
  logic                            w_lane_last;
  logic [AXI_DATA_WIDTH-1:0]       w_beat_next;

  generate
    if (SWAP_ENDIANESS != 0) begin : g_swap
      for (genvar b = 0; b < c_BYTES; b++) begin : g_byte
        assign w_flit_swapped[8*b +: 8] = noc_data_in[8*(c_BYTES-1-b) +: 8];
      end
    end else begin : g_no_swap
      assign w_flit_swapped = noc_data_in;
    end
  endgenerate

  assign w_hdr_len   = noc_data_in[c_MSG_LENGTH_LO +: c_MSG_LENGTH_WIDTH];
  assign w_hdr_type  = noc_data_in[c_MSG_TYPE_LO +: c_MSG_TYPE_WIDTH];
  assign w_hdr_class = classify_msg(w_hdr_type);
  assign w_txn_avail = !w_txn_empty;
  assign w_hdr_match = w_txn_head ? (w_hdr_class == MSG_CLASS_STORE)
                                  : (w_hdr_class == MSG_CLASS_LOAD);
  assign w_last_flit = ((r_flit_cnt + c_CNT_ONE) == r_msg_len);
  assign w_lane_last = (r_lane == c_LANE_LAST);

  assign txn_ready_out = !w_txn_full && !rst;
  assign w_txn_push    = txn_valid_in && txn_ready_out;

  sync_fifo #(
    .WIDTH (1),
    .DEPTH (TXN_DEPTH)
  ) u_txn_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (w_txn_push),
    .wr_data (txn_is_store),
    .full    (w_txn_full),
    .rd_en   (w_txn_pop),
    .rd_data (w_txn_head),
    .empty   (w_txn_empty)
  );

  sync_fifo #(
    .WIDTH (c_RD_W),
    .DEPTH (RDATA_DEPTH)
  ) u_rdata_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (w_rd_push),
    .wr_data (w_rd_push_data),
    .full    (w_rd_full),
    .rd_en   (w_rd_pop),
    .rd_data (w_rd_head),
    .empty   (w_rd_empty)
  );

  always_comb begin
    w_beat_next = r_beat;
    w_beat_next[r_lane*NOC_DATA_WIDTH +: NOC_DATA_WIDTH] = w_flit_swapped;
  end

  always_comb begin
    w_noc_ready    = 1'b0;
    w_txn_pop      = 1'b0;
    w_rd_push      = 1'b0;
    w_rd_push_data = '0;
    case (r_state)
      // A header that answers a load may need an R slot at once; hold it off while R is full.
      c_ST_HEADER:    w_noc_ready = !(w_txn_avail && !w_txn_head && w_rd_full);
      c_ST_LOAD_DATA: w_noc_ready = !w_rd_full;
      c_ST_DROP:      w_noc_ready = 1'b1;
      default:        w_noc_ready = 1'b0;
    endcase
    if (rst) begin
      w_noc_ready = 1'b0;
    end
    w_noc_fire = noc_valid_in && w_noc_ready;

    if ((r_state == c_ST_HEADER) && w_noc_fire && w_txn_avail) begin
      w_txn_pop = 1'b1;
      if (!w_txn_head && (!w_hdr_match || (w_hdr_len == '0))) begin
        w_rd_push      = 1'b1;
        w_rd_push_data = {(w_hdr_match ? c_AXI_RESP_OKAY : c_AXI_RESP_SLVERR),
                          {AXI_DATA_WIDTH{1'b0}}};
      end
    end
    if ((r_state == c_ST_LOAD_DATA) && w_noc_fire && (w_lane_last || w_last_flit)) begin
      w_rd_push      = 1'b1;
      w_rd_push_data = {c_AXI_RESP_OKAY, w_beat_next};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= c_ST_HEADER;
      r_msg_len  <= '0;
      r_flit_cnt <= '0;
      r_lane     <= '0;
      r_beat     <= '0;
      r_bvalid   <= 1'b0;
      r_bresp    <= c_AXI_RESP_OKAY;
      r_err      <= 1'b0;
    end else begin
      r_err <= 1'b0;
      case (r_state)
        c_ST_HEADER: begin
          if (w_noc_fire) begin
            r_msg_len  <= w_hdr_len;
            r_flit_cnt <= '0;
            r_lane     <= '0;
            r_beat     <= '0;
            if (!w_txn_avail) begin
              r_err   <= 1'b1;
              r_state <= (w_hdr_len != '0) ? c_ST_DROP : c_ST_HEADER;
            end else if (w_txn_head) begin
              r_bvalid <= 1'b1;
              r_bresp  <= w_hdr_match ? c_AXI_RESP_OKAY : c_AXI_RESP_SLVERR;
              r_state  <= c_ST_BRESP;
            end else if (w_hdr_match && (w_hdr_len != '0)) begin
              r_state <= c_ST_LOAD_DATA;
            end else begin
              r_state <= (w_hdr_len != '0) ? c_ST_DROP : c_ST_HEADER;
            end
          end
        end
        c_ST_LOAD_DATA: begin
          if (w_noc_fire) begin
            r_flit_cnt <= r_flit_cnt + c_CNT_ONE;
            if (w_last_flit || w_lane_last) begin
              r_beat <= '0;
              r_lane <= '0;
            end else begin
              r_beat <= w_beat_next;
              r_lane <= r_lane + c_LANE_W'(1);
            end
            if (w_last_flit) begin
              r_state <= c_ST_HEADER;
            end
          end
        end
        c_ST_BRESP: begin
          // Payload of a store ack (or mismatched load ack) is drained only after B completes.
          if (m_axi_bready) begin
            r_bvalid <= 1'b0;
            r_state  <= (r_msg_len != '0) ? c_ST_DROP : c_ST_HEADER;
          end
        end
        c_ST_DROP: begin
          if (w_noc_fire) begin
            r_flit_cnt <= r_flit_cnt + c_CNT_ONE;
            if (w_last_flit) begin
              r_state <= c_ST_HEADER;
            end
          end
        end
        default: r_state <= c_ST_HEADER;
      endcase
    end
  end

  assign w_rd_pop       = m_axi_rvalid && m_axi_rready;
  assign noc_ready_out  = w_noc_ready;
  assign m_axi_rvalid   = !w_rd_empty;
  assign m_axi_rdata    = m_axi_rvalid ? w_rd_head[AXI_DATA_WIDTH-1:0] : '0;
  assign m_axi_rresp    = m_axi_rvalid ? w_rd_head[c_RD_W-1 -: 2] : 2'b00;
  assign m_axi_bvalid   = r_bvalid;
  assign m_axi_bresp    = r_bresp;
  assign err_unexpected = r_err;

endmodule
`default_nettype wire

// File: tb/tb_noc_response_axi_gen.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | tb_noc_response_axi_gen                                                |
// | Self-checking bench: directed scenarios plus randomized message mix.  |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
module tb_noc_response_axi_gen;

  localparam int NW = 64;
  localparam int AW = 512;
  localparam int RATIO = AW / NW;
  localparam logic [7:0] T_NC_LOAD  = 8'd26;
  localparam logic [7:0] T_NC_STORE = 8'd27;
  localparam logic [7:0] T_NODATA   = 8'd28;
  localparam logic [7:0] T_DATA     = 8'd29;
  localparam logic [7:0] T_OTHER    = 8'd5;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          noc_valid_in = 1'b0;
  logic [NW-1:0] noc_data_in = '0;
  logic          noc_ready_out;
  logic          txn_valid_in = 1'b0;
  logic          txn_is_store = 1'b0;
  logic          txn_ready_out;
  logic [AW-1:0] m_axi_rdata;
  logic [1:0]    m_axi_rresp;
  logic          m_axi_rvalid;
  logic          m_axi_rready = 1'b1;
  logic [1:0]    m_axi_bresp;
  logic          m_axi_bvalid;
  logic          m_axi_bready = 1'b1;
  logic          err_unexpected;

  noc_response_axi_gen #(
    .NOC_DATA_WIDTH (NW),
    .AXI_DATA_WIDTH (AW),
    .SWAP_ENDIANESS (1),
    .TXN_DEPTH      (16),
    .RDATA_DEPTH    (4)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .noc_valid_in   (noc_valid_in),
    .noc_data_in    (noc_data_in),
    .noc_ready_out  (noc_ready_out),
    .txn_valid_in   (txn_valid_in),
    .txn_is_store   (txn_is_store),
    .txn_ready_out  (txn_ready_out),
    .m_axi_rdata    (m_axi_rdata),
    .m_axi_rresp    (m_axi_rresp),
    .m_axi_rvalid   (m_axi_rvalid),
    .m_axi_rready   (m_axi_rready),
    .m_axi_bresp    (m_axi_bresp),
    .m_axi_bvalid   (m_axi_bvalid),
    .m_axi_bready   (m_axi_bready),
    .err_unexpected (err_unexpected)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int err_cnt = 0;
  int flit_cnt = 0;
  int act_cnt = 0;
  bit rnd_en = 1'b0;

  logic [AW-1:0] obs_r_data[$];
  logic [1:0]    obs_r_resp[$];
  logic [1:0]    obs_b_resp[$];
  logic [AW-1:0] exp_r_data[$];
  logic [1:0]    exp_r_resp[$];
  logic [1:0]    exp_b_resp[$];
  logic [NW-1:0] cur_pl[$];

  always @(negedge clk) begin
    if (m_axi_rvalid && m_axi_rready) begin
      obs_r_data.push_back(m_axi_rdata);
      obs_r_resp.push_back(m_axi_rresp);
    end
    if (m_axi_bvalid && m_axi_bready) obs_b_resp.push_back(m_axi_bresp);
    if (err_unexpected) err_cnt++;
    if (noc_valid_in && noc_ready_out) flit_cnt++;
    if (m_axi_rvalid || m_axi_bvalid) act_cnt++;
  end

  function automatic logic [NW-1:0] bswap(input logic [NW-1:0] x);
    logic [NW-1:0] y;
    for (int i = 0; i < NW / 8; i++) y[8*i +: 8] = x[8*(NW/8-1-i) +: 8];
    return y;
  endfunction

  function automatic logic [NW-1:0] mk_hdr(input logic [7:0] t, input int len);
    logic [NW-1:0] h;
    h = '0;
    h[29:22] = 8'(len);
    h[21:14] = t;
    return h;
  endfunction

  // Expected beats for a matched load: flits packed little-lane-first, RATIO per beat.
  function automatic void add_load_beats();
    int n;
    logic [AW-1:0] beat;
    n = cur_pl.size();
    for (int b = 0; b < (n + RATIO - 1) / RATIO; b++) begin
      beat = '0;
      for (int l = 0; l < RATIO; l++)
        if (b * RATIO + l < n) beat[l*NW +: NW] = bswap(cur_pl[b*RATIO+l]);
      exp_r_data.push_back(beat);
      exp_r_resp.push_back(2'b00);
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_flit(input logic [NW-1:0] d);
    int n;
    n = 0;
    noc_valid_in = 1'b1;
    noc_data_in  = d;
    @(negedge clk);
    while (!noc_ready_out && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) begin
      checks++;
      failures++;
      $display("FAIL flit_handshake_timeout: noc_ready_out=%0b after %0d cycles, required 1", noc_ready_out, n);
    end
    @(posedge clk);
    #1;
    noc_valid_in = 1'b0;
  endtask

  task automatic push_txn(input logic is_store);
    int n;
    n = 0;
    txn_valid_in = 1'b1;
    txn_is_store = is_store;
    @(negedge clk);
    while (!txn_ready_out && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) begin
      checks++;
      failures++;
      $display("FAIL txn_handshake_timeout: txn_ready_out=%0b, required 1", txn_ready_out);
    end
    @(posedge clk);
    #1;
    txn_valid_in = 1'b0;
  endtask

  task automatic send_msg(input logic [7:0] t, input int len);
    logic [NW-1:0] f;
    cur_pl.delete();
    send_flit(mk_hdr(t, len));
    for (int k = 0; k < len; k++) begin
      f = {$urandom, $urandom};
      cur_pl.push_back(f);
      send_flit(f);
    end
  endtask

  task automatic wait_counts(input int nr, input int nb);
    int n;
    n = 0;
    while ((obs_r_data.size() < nr || obs_b_resp.size() < nb) && n < 3000) begin
      tick();
      n++;
    end
  endtask

  task automatic clear_all();
    obs_r_data.delete(); obs_r_resp.delete(); obs_b_resp.delete();
    exp_r_data.delete(); exp_r_resp.delete(); exp_b_resp.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    checks++;
    if ({noc_ready_out, txn_ready_out, m_axi_rvalid, m_axi_bvalid, err_unexpected} !== 5'b0) begin
      failures++;
      $display("FAIL reset_outputs: nrdy,trdy,rv,bv,err=%b required 00000",
               {noc_ready_out, txn_ready_out, m_axi_rvalid, m_axi_bvalid, err_unexpected});
    end
    checks++;
    if (m_axi_rdata !== '0 || m_axi_rresp !== 2'b00 || m_axi_bresp !== 2'b00) begin
      failures++;
      $display("FAIL reset_data: rresp=%b bresp=%b required 00/00 and zero rdata", m_axi_rresp, m_axi_bresp);
    end
    rst = 1'b0;
    tick();
    checks++;
    if (noc_ready_out !== 1'b1 || txn_ready_out !== 1'b1) begin
      failures++;
      $display("FAIL post_reset_ready: noc_ready=%b txn_ready=%b required 1/1", noc_ready_out, txn_ready_out);
    end
  endtask

  task automatic test_load_full();
    logic [NW-1:0] f;
    clear_all();
    push_txn(1'b0);
    cur_pl.delete();
    send_flit(mk_hdr(T_DATA, 8));
    for (int k = 0; k < 8; k++) begin
      f = 64'h0102030405060708 + 64'(k) * 64'h0808080808080808;
      cur_pl.push_back(f);
      send_flit(f);
    end
    add_load_beats();
    wait_counts(1, 0);
    checks++;
    if (obs_r_data.size() != 1) begin
      failures++;
      $display("FAIL load_full_count: beats=%0d required 1", obs_r_data.size());
    end else begin
      checks++;
      if (obs_r_data[0][63:0] !== 64'h0807060504030201) begin
        failures++;
        $display("FAIL load_full_lane0: got %h required 0807060504030201", obs_r_data[0][63:0]);
      end
      checks++;
      if (obs_r_data[0] !== exp_r_data[0] || obs_r_resp[0] !== 2'b00) begin
        failures++;
        $display("FAIL load_full_beat: got %h resp %b required %h resp 00",
                 obs_r_data[0], obs_r_resp[0], exp_r_data[0]);
      end
    end
  endtask

  task automatic test_load_partial();
    logic [NW-1:0] f [3];
    logic [AW-1:0] expb;
    clear_all();
    m_axi_rready = 1'b0;
    push_txn(1'b0);
    send_flit(mk_hdr(T_NC_LOAD, 3));
    expb = '0;
    for (int k = 0; k < 3; k++) begin
      f[k] = {$urandom, $urandom};
      expb[k*NW +: NW] = bswap(f[k]);
    end
    send_flit(f[0]);
    send_flit(f[1]);
    checks++;
    if (m_axi_rvalid !== 1'b0) begin
      failures++;
      $display("FAIL partial_early_rvalid: rvalid=%b required 0", m_axi_rvalid);
    end
    send_flit(f[2]);
    checks++;
    if (m_axi_rvalid !== 1'b1) begin
      failures++;
      $display("FAIL partial_latency: rvalid=%b one cycle after last flit, required 1", m_axi_rvalid);
    end
    checks++;
    if (m_axi_rdata !== expb || m_axi_rresp !== 2'b00) begin
      failures++;
      $display("FAIL partial_beat: got %h resp %b required %h resp 00", m_axi_rdata, m_axi_rresp, expb);
    end
    m_axi_rready = 1'b1;
    tick(); tick();
    checks++;
    if (m_axi_rvalid !== 1'b0 || obs_r_data.size() != 1) begin
      failures++;
      $display("FAIL partial_pop: rvalid=%b beats=%0d required 0/1", m_axi_rvalid, obs_r_data.size());
    end
  endtask

  task automatic test_store_hold();
    clear_all();
    m_axi_bready = 1'b0;
    push_txn(1'b1);
    send_flit(mk_hdr(T_NODATA, 0));
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (m_axi_bvalid !== 1'b1 || noc_ready_out !== 1'b0 || m_axi_bresp !== 2'b00) begin
        failures++;
        $display("FAIL store_hold_cycle%0d: bvalid=%b noc_ready=%b bresp=%b required 1/0/00",
                 i, m_axi_bvalid, noc_ready_out, m_axi_bresp);
      end
      tick();
    end
    m_axi_bready = 1'b1;
    tick();
    checks++;
    if (m_axi_bvalid !== 1'b0 || noc_ready_out !== 1'b1 || obs_b_resp.size() != 1) begin
      failures++;
      $display("FAIL store_release: bvalid=%b noc_ready=%b bcount=%0d required 0/1/1",
               m_axi_bvalid, noc_ready_out, obs_b_resp.size());
    end
  endtask

  task automatic test_unexpected();
    int e0, f0, a0;
    clear_all();
    e0 = err_cnt; f0 = flit_cnt; a0 = act_cnt;
    send_msg(T_DATA, 2);
    repeat (4) tick();
    checks++;
    if (err_cnt - e0 != 1) begin
      failures++;
      $display("FAIL unexpected_err_pulses: got %0d required 1", err_cnt - e0);
    end
    checks++;
    if (flit_cnt - f0 != 3 || act_cnt - a0 != 0) begin
      failures++;
      $display("FAIL unexpected_consume: flits=%0d rb_active=%0d required 3/0", flit_cnt - f0, act_cnt - a0);
    end
  endtask

  task automatic test_mismatch();
    int e0;
    clear_all();
    push_txn(1'b0);
    send_msg(T_NC_STORE, 0);
    wait_counts(1, 0);
    checks++;
    if (obs_r_data.size() != 1) begin
      failures++;
      $display("FAIL mismatch_count: beats=%0d required 1", obs_r_data.size());
    end else begin
      checks++;
      if (obs_r_data[0] !== '0 || obs_r_resp[0] !== 2'b10) begin
        failures++;
        $display("FAIL mismatch_beat: data %h resp %b required zero resp 10", obs_r_data[0], obs_r_resp[0]);
      end
    end
    e0 = err_cnt;
    send_msg(T_DATA, 0);
    repeat (3) tick();
    checks++;
    if (err_cnt - e0 != 1) begin
      failures++;
      $display("FAIL mismatch_txn_popped: err pulses=%0d required 1", err_cnt - e0);
    end
  endtask

  task automatic test_backpressure();
    logic [NW-1:0] f;
    clear_all();
    m_axi_rready = 1'b0;
    repeat (4) push_txn(1'b0);
    for (int m = 0; m < 3; m++) begin
      send_msg(T_DATA, 2);
      add_load_beats();
    end
    cur_pl.delete();
    send_flit(mk_hdr(T_DATA, 10));
    for (int k = 0; k < 8; k++) begin
      f = {$urandom, $urandom};
      cur_pl.push_back(f);
      send_flit(f);
    end
    f = {$urandom, $urandom};
    cur_pl.push_back(f);
    noc_valid_in = 1'b1;
    noc_data_in  = f;
    repeat (3) tick();
    checks++;
    if (noc_ready_out !== 1'b0 || m_axi_rvalid !== 1'b1 || obs_r_data.size() != 0) begin
      failures++;
      $display("FAIL backpressure_stall: noc_ready=%b rvalid=%b popped=%0d required 0/1/0",
               noc_ready_out, m_axi_rvalid, obs_r_data.size());
    end
    m_axi_rready = 1'b1;
    send_flit(f);
    f = {$urandom, $urandom};
    cur_pl.push_back(f);
    send_flit(f);
    add_load_beats();
    wait_counts(5, 0);
    checks++;
    if (obs_r_data.size() != exp_r_data.size()) begin
      failures++;
      $display("FAIL backpressure_count: beats=%0d required %0d", obs_r_data.size(), exp_r_data.size());
    end else begin
      for (int i = 0; i < exp_r_data.size(); i++) begin
        checks++;
        if (obs_r_data[i] !== exp_r_data[i] || obs_r_resp[i] !== exp_r_resp[i]) begin
          failures++;
          $display("FAIL backpressure_beat%0d: got %h resp %b required %h resp %b",
                   i, obs_r_data[i], obs_r_resp[i], exp_r_data[i], exp_r_resp[i]);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    int e0;
    clear_all();
    push_txn(1'b0);
    push_txn(1'b1);
    send_flit(mk_hdr(T_DATA, 8));
    repeat (3) send_flit({$urandom, $urandom});
    rst = 1'b1;
    #1;
    checks++;
    if (noc_ready_out !== 1'b0 || txn_ready_out !== 1'b0 || m_axi_rvalid !== 1'b0) begin
      failures++;
      $display("FAIL midreset_async: noc_ready=%b txn_ready=%b rvalid=%b required 0/0/0",
               noc_ready_out, txn_ready_out, m_axi_rvalid);
    end
    tick(); tick();
    rst = 1'b0;
    tick();
    e0 = err_cnt;
    send_msg(T_NODATA, 0);
    repeat (3) tick();
    checks++;
    if (err_cnt - e0 != 1 || m_axi_bvalid !== 1'b0) begin
      failures++;
      $display("FAIL midreset_txn_discard: err pulses=%0d bvalid=%b required 1/0", err_cnt - e0, m_axi_bvalid);
    end
    push_txn(1'b0);
    send_msg(T_DATA, 1);
    add_load_beats();
    wait_counts(1, 0);
    checks++;
    if (obs_r_data.size() != 1 || obs_r_data[0] !== exp_r_data[0]) begin
      failures++;
      $display("FAIL midreset_clean_beat: beats=%0d data %h required 1 beat %h",
               obs_r_data.size(), obs_r_data[0], exp_r_data[0]);
    end
  endtask

  task automatic test_random();
    int e0, len, tsel;
    logic [7:0] t;
    logic [7:0] types [5];
    bit unexp, st, is_ld, is_st;
    types[0] = T_DATA; types[1] = T_NC_LOAD; types[2] = T_NODATA;
    types[3] = T_NC_STORE; types[4] = T_OTHER;
    clear_all();
    e0 = err_cnt;
    rnd_en = 1'b1;
    fork
      begin
        while (rnd_en) begin
          tick();
          m_axi_rready = ($urandom_range(0, 3) != 0);
          m_axi_bready = ($urandom_range(0, 2) != 0);
        end
      end
    join_none
    for (int m = 0; m < 40; m++) begin
      unexp = ($urandom_range(0, 7) == 0);
      tsel  = $urandom_range(0, 4);
      t     = types[tsel];
      len   = $urandom_range(0, 12);
      is_ld = (t == T_DATA) || (t == T_NC_LOAD);
      is_st = (t == T_NODATA) || (t == T_NC_STORE);
      if (unexp) begin
        send_msg(t, len);
      end else begin
        st = 1'($urandom_range(0, 1));
        push_txn(st);
        send_msg(t, len);
        if (st) begin
          exp_b_resp.push_back(is_st ? 2'b00 : 2'b10);
        end else if (!is_ld) begin
          exp_r_data.push_back('0);
          exp_r_resp.push_back(2'b10);
        end else if (len == 0) begin
          exp_r_data.push_back('0);
          exp_r_resp.push_back(2'b00);
        end else begin
          add_load_beats();
        end
      end
      if (unexp) begin
        exp_r_resp.push_back(2'b11);
        void'(exp_r_resp.pop_back());
      end
    end
    wait_counts(exp_r_data.size(), exp_b_resp.size());
    repeat (4) tick();
    rnd_en = 1'b0;
    tick(); tick();
    m_axi_rready = 1'b1;
    m_axi_bready = 1'b1;
    checks++;
    if (obs_r_data.size() != exp_r_data.size() || obs_b_resp.size() != exp_b_resp.size()) begin
      failures++;
      $display("FAIL random_counts: R=%0d B=%0d required R=%0d B=%0d",
               obs_r_data.size(), obs_b_resp.size(), exp_r_data.size(), exp_b_resp.size());
    end else begin
      for (int i = 0; i < exp_r_data.size(); i++) begin
        checks++;
        if (obs_r_data[i] !== exp_r_data[i] || obs_r_resp[i] !== exp_r_resp[i]) begin
          failures++;
          $display("FAIL random_r%0d: got %h resp %b required %h resp %b",
                   i, obs_r_data[i], obs_r_resp[i], exp_r_data[i], exp_r_resp[i]);
        end
      end
      for (int i = 0; i < exp_b_resp.size(); i++) begin
        checks++;
        if (obs_b_resp[i] !== exp_b_resp[i]) begin
          failures++;
          $display("FAIL random_b%0d: bresp %b required %b", i, obs_b_resp[i], exp_b_resp[i]);
        end
      end
    end
  endtask

  int exp_unexp_total;

  initial begin
    test_reset();
    test_load_full();
    test_load_partial();
    test_store_hold();
    test_unexpected();
    test_mismatch();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
